bsg_mul_iterative_scheduler: RTL

// Shares one bsg_mul_iterative instance among num_req_p requesters.
// - Picks one pending request per operation with a round-robin arbiter and registers its operands.
// - Issues the operands to the multiplier and waits for the result.
// - Buffers the result and returns it to the winning requester under valid/yumi.
// - One operation in flight at a time, which matches the multiplier's single-outstanding protocol.
//

---
 rtl/bsg_mul_iterative_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bsg_mul_iterative_scheduler.sv
// bsg_mul_iterative_scheduler
// Shares one iterative multiplier among num_req_p requesters. A round-robin
// arbiter picks one request, its operands are registered and issued, and the
// buffered result is returned to the winner under valid/yumi. Only one
// operation is ever outstanding at the multiplier.
module bsg_mul_iterative_scheduler #(
  parameter int num_req_p    = 4,
  parameter int width_p      = 32,
  parameter int full_sized_p = 1,
  localparam int res_w_lp    = (full_sized_p != 0) ? 2*width_p : width_p,
  localparam int tag_w_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_req_p-1:0]         v_i,
  output logic [num_req_p-1:0]         ready_o,
  input  logic [num_req_p*width_p-1:0] opA_i,
  input  logic [num_req_p-1:0]         opA_is_signed_i,
  input  logic [num_req_p*width_p-1:0] opB_i,
  input  logic [num_req_p-1:0]         opB_is_signed_i,
  output logic [num_req_p-1:0]         v_o,
  output logic [res_w_lp-1:0]          result_o,
  input  logic [num_req_p-1:0]         yumi_i,
  output logic                         mul_v_o,
  input  logic                         mul_ready_i,
  output logic [width_p-1:0]           mul_opA_o,
  output logic                         mul_opA_is_signed_o,
  output logic [width_p-1:0]           mul_opB_o,
  output logic                         mul_opB_is_signed_o,
  input  logic                         mul_v_i,
  input  logic [res_w_lp-1:0]          mul_result_i,
  output logic                         mul_yumi_o
);

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eISSUE = 2'd1,
    eWAIT  = 2'd2,
    eRESP  = 2'd3
  } state_e;

  localparam logic [num_req_p-1:0] one_hot_base_lp = {{(num_req_p-1){1'b0}}, 1'b1};

  state_e                state_r, state_n;
  logic                  live_r;
  logic [tag_w_lp-1:0]   rr_ptr_r, tag_r, next_ptr_s;
  logic [tag_w_lp-1:0]   offset_s, winner_s;
  logic [tag_w_lp:0]     sum_s;
  logic [num_req_p-1:0]  v_rot_s, grant_s;
  logic                  any_v_s;
  logic                  accept_s, capture_s, resp_done_s;
  logic [width_p-1:0]    opA_r, opB_r;
  logic                  opA_signed_r, opB_signed_r;
  logic [res_w_lp-1:0]   result_r;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit
  always_comb begin
    v_rot_s  = (v_i >> rr_ptr_r) | (v_i << (num_req_p - int'(rr_ptr_r)));
    offset_s = '0;
    for (int i = num_req_p-1; i >= 0; i--) begin
      offset_s = v_rot_s[i] ? tag_w_lp'(i) : offset_s;
    end
    any_v_s  = |v_i;
    sum_s    = {1'b0, rr_ptr_r} + {1'b0, offset_s};
    winner_s = (sum_s >= (tag_w_lp+1)'(num_req_p))
             ? tag_w_lp'(sum_s - (tag_w_lp+1)'(num_req_p))
             : sum_s[tag_w_lp-1:0];
    grant_s  = any_v_s ? (one_hot_base_lp << winner_s) : '0;
    next_ptr_s = (tag_r == tag_w_lp'(num_req_p-1)) ? '0 : tag_r + tag_w_lp'(1);
  end

  // Next-state and handshake outputs; live_r keeps grants and consumes quiet until the first edge after reset
  always_comb begin
    state_n     = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    resp_done_s = 1'b0;
    ready_o     = '0;
    v_o         = '0;
    mul_v_o     = 1'b0;
    mul_yumi_o  = 1'b0;
    case (state_r)
      eIDLE: begin
        ready_o    = live_r ? grant_s : '0;
        mul_yumi_o = mul_v_i & live_r;     // stale result left over from a reset
        if (any_v_s && live_r) begin
          accept_s = 1'b1;
          state_n  = eISSUE;
        end else begin
          state_n  = eIDLE;
        end
      end
      eISSUE: begin
        mul_v_o    = 1'b1;
        mul_yumi_o = mul_v_i;              // stale result left over from a reset
        if (mul_ready_i) begin
          state_n = eWAIT;
        end else begin
          state_n = eISSUE;
        end
      end
      eWAIT: begin
        mul_yumi_o = mul_v_i;
        if (mul_v_i) begin
          capture_s = 1'b1;
          state_n   = eRESP;
        end else begin
          state_n   = eWAIT;
        end
      end
      eRESP: begin
        v_o = one_hot_base_lp << tag_r;
        if (yumi_i[tag_r]) begin
          resp_done_s = 1'b1;
          state_n     = eIDLE;
        end else begin
          state_n     = eRESP;
        end
      end
      default: begin
        state_n = eIDLE;
      end
    endcase
  end

  // FSM state, owner tag, round-robin pointer and post-reset enable
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eIDLE;
      live_r   <= 1'b0;
      tag_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_n;
      live_r  <= 1'b1;
      if (accept_s) begin
        tag_r <= winner_s;
      end
      if (resp_done_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  // Operand registers loaded from the winning requester on accept
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      opA_r        <= '0;
      opB_r        <= '0;
      opA_signed_r <= 1'b0;
      opB_signed_r <= 1'b0;
    end else if (accept_s) begin
      opA_r        <= opA_i[winner_s*width_p +: width_p];
      opB_r        <= opB_i[winner_s*width_p +: width_p];
      opA_signed_r <= opA_is_signed_i[winner_s];
      opB_signed_r <= opB_is_signed_i[winner_s];
    end
  end

  // Result buffer, held until the owning requester consumes it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      result_r <= '0;
    end else if (capture_s) begin
      result_r <= mul_result_i;
    end
  end

  assign result_o            = result_r;
  assign mul_opA_o           = opA_r;
  assign mul_opB_o           = opB_r;
  assign mul_opA_is_signed_o = opA_signed_r;
  assign mul_opB_is_signed_o = opB_signed_r;

endmodule
